// File: rtl/pio_input_debounce_irq.sv
// Avalon-MM input port for pushbuttons / slider switches.
// Per channel: 2-flop synchroniser, optional inversion, counter debounce,
// sticky edge capture (write-1-to-clear) and a maskable level interrupt.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   address    word offset: 0 DATA, 1 RAW, 2 IRQMASK, 3 EDGECAPTURE
//   chipselect slave select qualifying read/write
//   read       read strobe (readdata valid next cycle)
//   write      write strobe
//   writedata  write data, bits above WIDTH ignored
//   readdata   registered read data, zero-extended
//   in_port    asynchronous raw inputs
//   irq        level interrupt = |(edgecapture & irqmask)
module pio_input_debounce_irq #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] INV_MASK = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : '0;

  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] stable, stable_nxt, stable_d;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] irqmask, edgecapture;
  logic [WIDTH-1:0] rise, fall, ev;
  logic [31:0]      rd_mux;
  logic             wr_en, rd_en;
  logic             wd_unused;

  // Upper writedata bits have no destination.
  assign wd_unused = ^writedata;

  assign wr_en = chipselect & write;
  assign rd_en = chipselect & read;

  // Synchroniser; inversion applied on entry so everything downstream is active-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port ^ INV_MASK;
      s2 <= s1;
    end
  end

  // Debounce: a new level must persist DEBOUNCE_CYCLES edges; any return resets the count.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Edge selection on the debounced level.
  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  always_comb begin
    ev = '0;
    case (EDGE_TYPE)
      0:       ev = rise;
      1:       ev = fall;
      default: ev = rise | fall;
    endcase
  end

  // Read mux samples pre-write register values.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = 32'(stable);
      2'd1:    rd_mux = 32'(s2);
      2'd2:    rd_mux = 32'(irqmask);
      default: rd_mux = 32'(edgecapture);
    endcase
  end

  // Bus registers; a coincident event beats the write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d    <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      stable_d <= stable;
      if (wr_en && address == 2'd2) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      if (wr_en && address == 2'd3) begin
        edgecapture <= (edgecapture & ~writedata[WIDTH-1:0]) | ev;
      end else begin
        edgecapture <= edgecapture | ev;
      end
      if (rd_en) begin
        readdata <= rd_mux;
      end
    end
  end

  // Driven only by registers, so no glitches from inputs.
  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_input_debounce_irq.sv
// Bench for pio_input_debounce_irq: pushbutton instance (W=4, active-low, rising)
// and switch instance (W=10, active-high, both edges), scoreboarded against a
// cycle-level reference model of the port's documented behaviour.
module tb_pio_input_debounce_irq;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_cs, a_rd, a_wr, a_irq;
  logic [1:0]  a_addr;
  logic [31:0] a_wd, a_rdata;
  logic [3:0]  a_in;

  logic        b_reset, b_cs, b_rd, b_wr, b_irq;
  logic [1:0]  b_addr;
  logic [31:0] b_wd, b_rdata;
  logic [9:0]  b_in;

  pio_input_debounce_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .EDGE_TYPE(0)) u_a (
    .clk(clk), .reset(a_reset), .address(a_addr), .chipselect(a_cs), .read(a_rd),
    .write(a_wr), .writedata(a_wd), .readdata(a_rdata), .in_port(a_in), .irq(a_irq));

  pio_input_debounce_irq #(.WIDTH(10), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0), .EDGE_TYPE(2)) u_b (
    .clk(clk), .reset(b_reset), .address(b_addr), .chipselect(b_cs), .read(b_rd),
    .write(b_wr), .writedata(b_wd), .readdata(b_rdata), .in_port(b_in), .irq(b_irq));

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model state, one slot per instance.
  logic [31:0] m_s1 [2];
  logic [31:0] m_s2 [2];
  logic [31:0] m_st [2];
  logic [31:0] m_std[2];
  logic [31:0] m_msk[2];
  logic [31:0] m_ec [2];
  int          m_run[2][32];

  typedef struct packed {
    logic        unit;
    logic [1:0]  addr;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  // Level becomes accepted once the synchronised input has disagreed with it
  // for D consecutive clocks.
  task automatic model_step(input int u, input int w, input bit al, input int et,
                            input logic rst, input logic [31:0] inp, input logic cs,
                            input logic rd, input logic wr, input logic [1:0] adr,
                            input logic [31:0] wd);
    logic [31:0] wm, ev, rise, fall;
    exp_t e;
    wm = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (rst) begin
      m_s1[u] = '0; m_s2[u] = '0; m_st[u] = '0; m_std[u] = '0; m_msk[u] = '0; m_ec[u] = '0;
      for (int i = 0; i < 32; i++) m_run[u][i] = 0;
    end else begin
      rise = m_st[u] & ~m_std[u];
      fall = ~m_st[u] & m_std[u];
      ev = (et == 0) ? rise : (et == 1) ? fall : (rise | fall);
      if (cs && rd) begin
        e.unit = 1'(u);
        e.addr = adr;
        case (adr)
          2'd0: e.exp = m_st[u];
          2'd1: e.exp = m_s2[u];
          2'd2: e.exp = m_msk[u];
          default: e.exp = m_ec[u];
        endcase
        sb.push_back(e);
      end
      m_std[u] = m_st[u];
      if (cs && wr && adr == 2'd3) m_ec[u] = ((m_ec[u] & ~wd) | ev) & wm;
      else                          m_ec[u] = (m_ec[u] | ev) & wm;
      if (cs && wr && adr == 2'd2) m_msk[u] = wd & wm;
      for (int i = 0; i < w; i++) begin
        if (m_s2[u][i] != m_st[u][i]) begin
          m_run[u][i]++;
          if (m_run[u][i] == int'(D)) begin
            m_st[u][i] = m_s2[u][i];
            m_run[u][i] = 0;
          end
        end else begin
          m_run[u][i] = 0;
        end
      end
      m_s2[u] = m_s1[u];
      m_s1[u] = (inp ^ (al ? wm : 32'd0)) & wm;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 4, 1'b1, 0, a_reset, 32'(a_in), a_cs, a_rd, a_wr, a_addr, a_wd);
    model_step(1, 10, 1'b0, 2, b_reset, 32'(b_in), b_cs, b_rd, b_wr, b_addr, b_wd);
  end

  // Monitor: read responses land one edge after issue; irq checked every cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.unit) check($sformatf("b_read%0d", e.addr), b_rdata, e.exp);
      else        check($sformatf("a_read%0d", e.addr), a_rdata, e.exp);
    end
    if (!a_reset) check("a_irq", 32'(a_irq), 32'(|(m_ec[0] & m_msk[0])));
    if (!b_reset) check("b_irq", 32'(b_irq), 32'(|(m_ec[1] & m_msk[1])));
  end

  task automatic a_cyc(input logic [3:0] inp, input logic rd, input logic wr,
                       input logic [1:0] adr, input logic [31:0] wd);
    a_in = inp; a_cs = rd | wr; a_rd = rd; a_wr = wr; a_addr = adr; a_wd = wd;
    @(negedge clk);
  endtask

  task automatic b_cyc(input logic [9:0] inp, input logic rd, input logic wr,
                       input logic [1:0] adr, input logic [31:0] wd);
    b_in = inp; b_cs = rd | wr; b_rd = rd; b_wr = wr; b_addr = adr; b_wd = wd;
    @(negedge clk);
  endtask

  task automatic a_idle(input int n);
    for (int i = 0; i < n; i++) a_cyc(a_in, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic b_idle(input int n);
    for (int i = 0; i < n; i++) b_cyc(b_in, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  int a_hold = 0;
  int b_hold = 0;

  initial begin
    a_reset = 1'b1; a_in = 4'hF; a_cs = 0; a_rd = 0; a_wr = 0; a_addr = 0; a_wd = 0;
    b_reset = 1'b1; b_in = 10'h0; b_cs = 0; b_rd = 0; b_wr = 0; b_addr = 0; b_wd = 0;
    @(negedge clk); @(negedge clk);
    check("a_rst_readdata", a_rdata, 32'd0);
    check("a_rst_irq", 32'(a_irq), 32'd0);
    a_reset = 1'b0; b_reset = 1'b0;

    // Reset state, idle buttons.
    a_cyc(4'hF, 1, 0, 2'd0, 0); check("a_rst_data", a_rdata, 32'd0);
    a_cyc(4'hF, 1, 0, 2'd3, 0); check("a_rst_ec", a_rdata, 32'd0);
    a_idle(100);

    // Press ch2: DATA visible on the read issued 6 edges after the press edge.
    a_cyc(4'hB, 0, 0, 2'd0, 0);
    a_idle(4);
    a_cyc(4'hB, 1, 0, 2'd0, 0); check("a_press_data_5", a_rdata, 32'd0);
    a_cyc(4'hB, 1, 0, 2'd0, 0); check("a_press_data_6", a_rdata, 32'h4);
    a_cyc(4'hB, 1, 0, 2'd3, 0); check("a_press_ec", a_rdata, 32'h4);
    check("a_press_irq_nomask", 32'(a_irq), 32'd0);

    // Masked interrupt.
    a_cyc(4'hF, 0, 0, 2'd0, 0);
    a_idle(10);
    a_cyc(4'hF, 0, 1, 2'd3, 32'h4);
    a_cyc(4'hF, 0, 1, 2'd2, 32'h4); check("a_mask_irq0", 32'(a_irq), 32'd0);
    a_cyc(4'hB, 0, 0, 2'd0, 0);
    a_idle(5); check("a_irq_before", 32'(a_irq), 32'd0);
    a_idle(1); check("a_irq_rise", 32'(a_irq), 32'd1);
    a_cyc(4'hB, 0, 1, 2'd3, 32'h1); check("a_clr_other", 32'(a_irq), 32'd1);
    a_cyc(4'hB, 0, 1, 2'd3, 32'h4); check("a_clr_irq", 32'(a_irq), 32'd0);
    a_cyc(4'hB, 1, 0, 2'd3, 0); check("a_clr_ec", a_rdata, 32'd0);

    // Glitch rejection then acceptance on ch0.
    a_cyc(4'hF, 0, 0, 2'd0, 0);
    a_idle(10);
    for (int i = 0; i < 3; i++) a_cyc(4'hE, 0, 0, 2'd0, 0);
    a_cyc(4'hF, 0, 0, 2'd0, 0);
    a_idle(10);
    a_cyc(4'hF, 1, 0, 2'd0, 0); check("a_glitch_data", a_rdata, 32'd0);
    a_cyc(4'hF, 1, 0, 2'd3, 0); check("a_glitch_ec", a_rdata, 32'd0);
    for (int i = 0; i < 4; i++) a_cyc(4'hE, 0, 0, 2'd0, 0);
    a_cyc(4'hF, 0, 0, 2'd0, 0);
    a_idle(12);
    a_cyc(4'hF, 1, 0, 2'd3, 0); check("a_pulse_ec", a_rdata, 32'h1);

    // Reset mid-count with ch1 held.
    a_cyc(4'hD, 0, 0, 2'd0, 0);
    a_cyc(4'hD, 0, 0, 2'd0, 0);
    a_reset = 1'b1;
    a_cyc(4'hD, 0, 0, 2'd0, 0);
    a_reset = 1'b0;
    check("a_midrst_irq", 32'(a_irq), 32'd0);
    a_cyc(4'hD, 1, 0, 2'd2, 0); check("a_midrst_mask", a_rdata, 32'd0);
    a_cyc(4'hD, 1, 0, 2'd3, 0); check("a_midrst_ec", a_rdata, 32'd0);
    a_cyc(4'hD, 1, 0, 2'd0, 0); check("a_midrst_data", a_rdata, 32'd0);
    for (int i = 0; i < 6; i++) a_cyc(4'hD, 1, 0, 2'd3, 0);
    check("a_recapture_ec", a_rdata, 32'h2);

    // Switch instance: both edges on sw9, clear coinciding with the event.
    b_cyc(10'h200, 0, 0, 2'd0, 0);
    b_idle(6);
    b_cyc(10'h200, 1, 0, 2'd3, 0); check("b_up_ec", b_rdata, 32'h200);
    b_cyc(10'h200, 0, 1, 2'd3, 32'h200);
    b_cyc(10'h200, 1, 0, 2'd3, 0); check("b_up_clr", b_rdata, 32'd0);
    b_cyc(10'h000, 0, 0, 2'd0, 0);
    b_idle(int'(D) + 1);
    b_cyc(10'h000, 0, 1, 2'd3, 32'h200);
    b_cyc(10'h000, 1, 0, 2'd3, 0); check("b_down_ec_wins", b_rdata, 32'h200);
    b_cyc(10'h000, 1, 0, 2'd0, 0); check("b_down_data", b_rdata, 32'd0);
    b_cyc(10'h000, 0, 1, 2'd1, 32'h3FF);
    b_cyc(10'h000, 1, 0, 2'd1, 0); check("b_raw_ignore_wr", b_rdata, 32'd0);

    // Randomised traffic on both instances against the model.
    for (int n = 0; n < 2000; n++) begin
      if (a_hold == 0) begin
        a_in = 4'($urandom);
        a_hold = $urandom_range(1, 8);
      end
      a_hold--;
      if (b_hold == 0) begin
        b_in = b_in ^ 10'(1 << $urandom_range(0, 9));
        b_hold = $urandom_range(1, 9);
      end
      b_hold--;
      a_cs = ($urandom_range(0, 3) != 0); a_rd = 1'($urandom); a_wr = ($urandom_range(0, 3) == 0);
      a_addr = 2'($urandom); a_wd = $urandom;
      a_reset = ($urandom_range(0, 299) == 0);
      b_cs = ($urandom_range(0, 3) != 0); b_rd = 1'($urandom); b_wr = ($urandom_range(0, 3) == 0);
      b_addr = 2'($urandom); b_wd = $urandom;
      b_reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    a_reset = 0; b_reset = 0;
    a_cs = 0; a_rd = 0; a_wr = 0; b_cs = 0; b_rd = 0; b_wr = 0;
    @(negedge clk); @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
